// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply-divide sequencer.
// Contents: MD op encodings, FSM state enum, op-class helpers, and default
// latencies/counter width.
package md_pkg;

  // MD op encodings carried on op_code; 3'd6 and 3'd7 are unused and ignored.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_CNT_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sched.sv
// Issue/sequencing controller for the HI/LO multiply-divide resource (E stage).
// Ports: clk/reset; op_valid/op_code/op_a/op_b/op_ready issue handshake; flush;
// md_use_d/stall_req hazard; busy; ar_* to/from the external arithmetic unit; hi/lo.
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        flush,
  input  logic        md_use_d,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] ar_a,
  output logic [31:0] ar_b,
  output logic        ar_signed,
  input  logic [63:0] ar_prod,
  input  logic [31:0] ar_quo,
  input  logic [31:0] ar_rem,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter load values: commit lands on the LAT-th edge after accept.
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [31:0]       ar_a_q, ar_a_d;
  logic [31:0]       ar_b_q, ar_b_d;
  logic              ar_signed_q, ar_signed_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;

  assign op_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_RUN);
  assign stall_req = md_use_d & (busy | (op_valid & op_ready & is_muldiv(op_code)));
  assign ar_a      = ar_a_q;
  assign ar_b      = ar_b_q;
  assign ar_signed = ar_signed_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    ar_a_d      = ar_a_q;
    ar_b_d      = ar_b_q;
    ar_signed_d = ar_signed_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    if (flush) begin
      // Cancel any in-flight op; nothing commits and no new op is taken.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            if (is_muldiv(op_code)) begin
              ar_a_d      = op_a;
              ar_b_d      = op_b;
              ar_signed_d = is_signed_op(op_code);
              div_d       = is_div(op_code);
              cnt_d       = is_div(op_code) ? DIV_CNT : MULT_CNT;
              state_d     = ST_RUN;
            end else if (op_code == MD_MTHI) begin
              hi_d = op_a;
            end else if (op_code == MD_MTLO) begin
              lo_d = op_a;
            end
          end
        end
        ST_RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            if (!div_q) begin
              hi_d = ar_prod[63:32];
              lo_d = ar_prod[31:0];
            end else if (ar_b_q == 32'd0) begin
              // Divide by zero: the arithmetic unit output is undefined.
              hi_d = ar_a_q;
              lo_d = 32'hFFFF_FFFF;
            end else if (ar_signed_q && ar_a_q == 32'h8000_0000 && ar_b_q == 32'hFFFF_FFFF) begin
              // Signed overflow case has no representable quotient.
              hi_d = 32'd0;
              lo_d = 32'h8000_0000;
            end else begin
              hi_d = ar_rem;
              lo_d = ar_quo;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_q       <= 1'b0;
      ar_a_q      <= '0;
      ar_b_q      <= '0;
      ar_signed_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      ar_a_q      <= ar_a_d;
      ar_b_q      <= ar_b_d;
      ar_signed_q <= ar_signed_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule
